// File: rtl/lcd_ctrl.sv
// HD44780 character-LCD controller: queues GO-toggle requests in a 4-deep FIFO and replays them with bus timing.
// Define LCD_AUTO_INIT_EN to run a power-on wait plus a fixed 4-command init sequence before serving the FIFO.
module lcd_ctrl #(
  parameter int unsigned TAS_CYC       = 3,
  parameter int unsigned EN_CYC        = 25,
  parameter int unsigned HOLD_CYC      = 3,
  parameter int unsigned EXEC_CYC      = 2000,
  parameter int unsigned SLOW_EXEC_CYC = 82000,
  parameter int unsigned INIT_CYC      = 750000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_lcd_word,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic        o_lcd_on,
  output logic        o_lcd_blon,
  output logic        o_busy,
  output logic        o_overflow
);

  function automatic int unsigned umax(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned MAX_CYC = umax(umax(umax(TAS_CYC, EN_CYC), umax(HOLD_CYC, EXEC_CYC)),
                                         umax(SLOW_EXEC_CYC, INIT_CYC));
  localparam int CW = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] TAS_LD  = CW'(TAS_CYC - 1);
  localparam logic [CW-1:0] EN_LD   = CW'(EN_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] EXEC_LD = CW'(EXEC_CYC - 1);
  localparam logic [CW-1:0] SLOW_LD = CW'(SLOW_EXEC_CYC - 1);
  localparam logic [CW-1:0] INIT_LD = CW'(INIT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_EXEC, S_INIT
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rs_q, rs_d;
  logic [7:0]      data_q, data_d;
  logic            go_q, on_q, blon_q, ovf_q;

  logic [3:0][8:0] fifo_q;
  logic [1:0]      wr_q, rd_q;
  logic [2:0]      count_q;
  logic            push, push_ok, pop, full, slow_cmd;
  logic [8:0]      req;

  logic unused_bits;
  assign unused_bits = ^{i_lcd_word[28:10], i_lcd_word[8]};

  // Request capture: any edge on GO is one request, including back-to-back toggles
  assign push    = i_lcd_word[30] ^ go_q;
  assign req     = {i_lcd_word[9], i_lcd_word[7:0]};
  assign full    = (count_q == 3'd4);
  assign push_ok = push && (!full || pop);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      go_q   <= 1'b0;
      on_q   <= 1'b0;
      blon_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      go_q   <= i_lcd_word[30];
      on_q   <= i_lcd_word[31];
      blon_q <= i_lcd_word[29];
      if (push && !push_ok) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      fifo_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) begin
        fifo_q[wr_q] <= req;
        wr_q         <= wr_q + 2'd1;
      end
      if (pop) rd_q <= rd_q + 2'd1;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Clear display / return home need the long execution time
  assign slow_cmd = !rs_q && (data_q == 8'h01 || data_q == 8'h02 || data_q == 8'h03);

`ifdef LCD_AUTO_INIT_EN
  logic       init_q, init_d;
  logic [1:0] idx_q, idx_d;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      init_q <= 1'b1;
      idx_q  <= 2'd0;
    end else begin
      init_q <= init_d;
      idx_q  <= idx_d;
    end
  end
`endif

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
`ifdef LCD_AUTO_INIT_EN
      state_q <= S_INIT;
      cnt_q   <= INIT_LD;
`else
      state_q <= S_IDLE;
      cnt_q   <= '0;
`endif
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rs_d    = rs_q;
    data_d  = data_q;
    pop     = 1'b0;
`ifdef LCD_AUTO_INIT_EN
    init_d  = init_q;
    idx_d   = idx_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (count_q != 3'd0) begin
          pop             = 1'b1;
          {rs_d, data_d}  = fifo_q[rd_q];
          state_d         = S_SETUP;
          cnt_d           = TAS_LD;
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_PULSE;
          cnt_d   = EN_LD;
        end else cnt_d = cnt_q - 1'b1;
      end
      S_PULSE: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
          cnt_d   = HOLD_LD;
        end else cnt_d = cnt_q - 1'b1;
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_EXEC;
          cnt_d   = slow_cmd ? SLOW_LD : EXEC_LD;
        end else cnt_d = cnt_q - 1'b1;
      end
      S_EXEC: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
`ifdef LCD_AUTO_INIT_EN
          // Init commands chain straight into the next SETUP without visiting IDLE
          if (init_q) begin
            if (idx_q == 2'd3) init_d = 1'b0;
            else begin
              idx_d   = idx_q + 2'd1;
              rs_d    = 1'b0;
              data_d  = init_cmd(idx_q + 2'd1);
              state_d = S_SETUP;
              cnt_d   = TAS_LD;
            end
          end
`endif
        end else cnt_d = cnt_q - 1'b1;
      end
`ifdef LCD_AUTO_INIT_EN
      S_INIT: begin
        if (cnt_q == '0) begin
          rs_d    = 1'b0;
          data_d  = init_cmd(2'd0);
          state_d = S_SETUP;
          cnt_d   = TAS_LD;
        end else cnt_d = cnt_q - 1'b1;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign o_lcd_data = data_q;
  assign o_lcd_rs   = rs_q;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_en   = (state_q == S_PULSE);
  assign o_lcd_on   = on_q;
  assign o_lcd_blon = blon_q;
  assign o_busy     = (state_q != S_IDLE) || (count_q != 3'd0);
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Self-checking bench for lcd_ctrl: vector table of single transfers, scoreboard of bus words seen at EN rise,
// plus FIFO overflow, reset-mid-pulse, panel-control and (with LCD_AUTO_INIT_EN) init-sequence checks.
module tb_lcd_ctrl;
  localparam int TAS  = 3;
  localparam int ENC  = 25;
  localparam int HLD  = 3;
  localparam int EXE  = 200;
  localparam int SLOW = 900;
  localparam int INIT = 100;
`ifdef LCD_AUTO_INIT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] word = 32'h0;
  logic [7:0]  lcd_data;
  logic        lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon, busy, ovf;

  lcd_ctrl #(
    .TAS_CYC(TAS), .EN_CYC(ENC), .HOLD_CYC(HLD),
    .EXEC_CYC(EXE), .SLOW_EXEC_CYC(SLOW), .INIT_CYC(INIT)
  ) dut (
    .i_clk(clk), .i_reset(rst_n), .i_lcd_word(word),
    .o_lcd_data(lcd_data), .o_lcd_rs(lcd_rs), .o_lcd_rw(lcd_rw), .o_lcd_en(lcd_en),
    .o_lcd_on(lcd_on), .o_lcd_blon(lcd_blon), .o_busy(busy), .o_overflow(ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  logic [8:0] sbq[$];
  int rises[$];
  bit en_prev = 1'b0;
  int rise_cyc = 0;
  bit go = 1'b0, on_b = 1'b0, blon_b = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: the bus word at each EN rise must match the oldest queued expectation
  always @(negedge clk) begin
    if (!rst_n) en_prev = 1'b0;
    else begin
      if (lcd_en && !en_prev) begin
        rise_cyc = cyc;
        rises.push_back(cyc);
        if (sbq.size() == 0) chk("unexpected_xfer", {lcd_rs, lcd_data}, 9'h1FF);
        else chk("xfer_bus", {23'd0, lcd_rs, lcd_data}, {23'd0, sbq.pop_front()});
        chk("rw_low", lcd_rw, 1'b0);
      end
      if (!lcd_en && en_prev) chk("en_width", cyc - rise_cyc, ENC);
      en_prev = lcd_en;
    end
  end

  task automatic drive(input logic rs, input logic [7:0] d);
    logic [31:0] w;
    w = $urandom;
    go = ~go;
    w[31] = on_b; w[30] = go; w[29] = blon_b; w[9] = rs; w[7:0] = d;
    word = w;
  endtask

  task automatic wait_idle(input int bound, input string name, output int t);
    int k;
    k = 0;
    @(negedge clk);
    while (busy && k < bound) begin
      @(negedge clk);
      k++;
    end
    if (busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: busy still 1 after %0d cycles, required 0", name, bound);
    end
    t = cyc;
  endtask

  typedef struct {
    logic       rs;
    logic [7:0] d;
    int         exec;
  } vec_t;

  initial begin
    vec_t vecs[8];
    int n0, t;
    vecs[0] = '{1'b1, 8'h41, EXE};
    vecs[1] = '{1'b0, 8'h01, SLOW};
    vecs[2] = '{1'b0, 8'h38, EXE};
    vecs[3] = '{1'b0, 8'h02, SLOW};
    vecs[4] = '{1'b0, 8'h03, SLOW};
    vecs[5] = '{1'b0, 8'h04, EXE};
    vecs[6] = '{1'b1, 8'h01, EXE};
    vecs[7] = '{1'b0, 8'h00, EXE};

    repeat (3) @(negedge clk);
    chk("rst_en", lcd_en, 1'b0);
    chk("rst_data", lcd_data, 8'h00);
    chk("rst_rs", lcd_rs, 1'b0);
    chk("rst_rw", lcd_rw, 1'b0);
    chk("rst_on", {lcd_on, lcd_blon}, 2'b00);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_busy", busy, AUTO);
    @(posedge clk); #2 rst_n = 1'b1;

`ifdef LCD_AUTO_INIT_EN
    sbq.push_back(9'h038); sbq.push_back(9'h00C); sbq.push_back(9'h001); sbq.push_back(9'h006);
    repeat (10) @(negedge clk);
    chk("init_busy", busy, 1'b1);
    drive(1'b1, 8'h7A);
    sbq.push_back(9'h17A);
    wait_idle(8000, "init_done", t);
    chk("init_xfers", rises.size(), 5);
    chk("init_sb_empty", sbq.size(), 0);
`endif

    foreach (vecs[i]) begin
      @(negedge clk);
      chk("pre_busy", busy, 1'b0);
      n0 = cyc;
      rises.delete();
      drive(vecs[i].rs, vecs[i].d);
      sbq.push_back({vecs[i].rs, vecs[i].d});
      @(negedge clk);
      chk("busy_rise", busy, 1'b1);
      wait_idle(3000, "vec_idle", t);
      chk("busy_fall_ofs", t - n0, 2 + TAS + ENC + HLD + vecs[i].exec);
      chk("en_rise_cnt", rises.size(), 1);
      if (rises.size() == 1) chk("en_rise_ofs", rises[0] - n0, 2 + TAS);
      chk("bus_hold", {lcd_rs, lcd_data}, {vecs[i].rs, vecs[i].d});
    end

    // Panel controls follow bits 31/29 one cycle later without any transfer
    @(negedge clk);
    rises.delete();
    on_b = 1'b1; blon_b = 1'b0;
    word[31] = 1'b1; word[29] = 1'b0;
    chk("on_before", lcd_on, 1'b0);
    @(negedge clk);
    chk("panel_on_only", {lcd_on, lcd_blon}, 2'b10);
    blon_b = 1'b1; word[29] = 1'b1;
    @(negedge clk);
    chk("panel_both", {lcd_on, lcd_blon}, 2'b11);
    repeat (50) @(negedge clk);
    chk("panel_no_en", rises.size(), 0);
    chk("panel_busy", busy, 1'b0);

    // Six toggles in consecutive cycles: first is popped, four queue, sixth overflows
    @(negedge clk);
    rises.delete();
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 8'h10 + 8'(k));
      if (k < 5) sbq.push_back({1'b0, 8'h10 + 8'(k)});
      if (k == 5) chk("ovf_before", ovf, 1'b0);
      @(negedge clk);
    end
    chk("ovf_set", ovf, 1'b1);
    wait_idle(3000, "fifo_idle", t);
    chk("fifo_xfers", rises.size(), 5);
    for (int k = 1; k < 5 && k < rises.size(); k++)
      chk("b2b_gap", rises[k] - rises[k-1], TAS + ENC + HLD + EXE + 1);
    chk("ovf_sticky", ovf, 1'b1);
    chk("fifo_last", {lcd_rs, lcd_data}, 9'h014);

    // Reset while EN is high aborts the transfer
    @(negedge clk);
    drive(1'b1, 8'h55);
    sbq.push_back(9'h155);
    for (int k = 0; k < 20 && !lcd_en; k++) @(negedge clk);
    chk("pulse_reached", lcd_en, 1'b1);
    repeat (5) @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    word = 32'h0; go = 1'b0; on_b = 1'b0; blon_b = 1'b0;
    #1;
    chk("rstp_en", lcd_en, 1'b0);
    chk("rstp_data", {lcd_rs, lcd_data}, 9'h000);
    chk("rstp_busy", busy, AUTO);
    chk("rstp_ovf", ovf, 1'b0);
    repeat (2) @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b1;
    rises.delete();
`ifdef LCD_AUTO_INIT_EN
    sbq.push_back(9'h038); sbq.push_back(9'h00C); sbq.push_back(9'h001); sbq.push_back(9'h006);
    wait_idle(8000, "reinit_idle", t);
    chk("post_rst_xfers", rises.size(), 4);
`else
    repeat (300) @(negedge clk);
    chk("post_rst_xfers", rises.size(), 0);
`endif
    chk("post_rst_busy", busy, 1'b0);
    chk("sb_empty", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: run did not finish, required finish");
    $fatal(1);
  end
endmodule

// File: doc/lcd_ctrl.md
# lcd_ctrl

HD44780-compatible character-LCD controller downstream of the load/store unit's LCD output register. It watches the 32-bit LCD word written by software, queues each requested transfer in a 4-entry FIFO, and replays it on the LCD pins with correct setup, enable-pulse, hold and execution-time spacing. Software triggers a transfer by toggling a single bit, so stores are non-blocking. Software never has to time the LCD bus itself.

## Interface
- `TAS_CYC`, 3: cycles RS/data are stable before EN rises.
- `EN_CYC`, 25: EN high width in cycles (500 ns at 50 MHz).
- `HOLD_CYC`, 3: cycles RS/data are held after EN falls.
- `EXEC_CYC`, 2000: post-transfer wait for normal commands and data (40 µs).
- `SLOW_EXEC_CYC`, 82000: post-transfer wait for clear/home commands (1.64 ms).
- `INIT_CYC`, 750000: power-on wait, used only with `LCD_AUTO_INIT_EN` (15 ms).
- `i_clk  in  1`: system clock.
- `i_reset  in  1`: asynchronous, active-low reset.
- `i_lcd_word  in  32`: LCD register from the LSU.
  - [31] ON.
  - [30] GO toggle.
  - [29] BLON.
  - [9] RS.
  - [7:0] data.
  - Other bits are ignored.
- `o_lcd_data  out  8`: LCD data bus.
- `o_lcd_rs  out  1`: register select.
- `o_lcd_rw  out  1`: read/write. Constant 0 (write-only).
- `o_lcd_en  out  1`: enable strobe.
- `o_lcd_on  out  1`: panel power.
- `o_lcd_blon  out  1`: backlight.
- `o_busy  out  1`: high while the FSM is not IDLE or the FIFO is non-empty.
- `o_overflow  out  1`: sticky flag for a dropped request.

## Operation
- **Reset state.** Asserting `i_reset` low immediately forces:
  - all outputs to 0, including `o_lcd_en` (a transfer in progress is aborted);
  - FIFO empty;
  - `go_prev` = 0;
  - FSM to IDLE, or to INIT_WAIT when `LCD_AUTO_INIT_EN` is defined.
- **Request detect.** Each cycle, `go_prev` <= `i_lcd_word[30]`. When `i_lcd_word[30]` != `go_prev`, push {RS, data[7:0]} (9 bits) into the FIFO.
- **FIFO.**
  - Depth 4; 2-bit read and write pointers with wrap-around, plus a 3-bit count.
  - Push and pop in the same cycle are both performed, and the count is unchanged.
  - A push when count==4 is dropped and sets `o_overflow`, which stays set until reset.
  - A push on a full FIFO in the same cycle as a pop is accepted.
- **FSM states.**
  - IDLE: if the FIFO is non-empty, pop the head, register it onto `o_lcd_rs`/`o_lcd_data`, and go to SETUP.
  - SETUP: EN=0 for `TAS_CYC` cycles, then go to PULSE.
  - PULSE: EN=1 for `EN_CYC` cycles, then go to HOLD.
  - HOLD: EN=0 for `HOLD_CYC` cycles, then go to EXEC.
  - EXEC: wait `SLOW_EXEC_CYC` cycles if RS=0 and data is 0x01, 0x02 or 0x03; otherwise wait `EXEC_CYC` cycles. Then return to IDLE.
- **Counter.** A single down-counter sized `$clog2` of the largest parameter + 1. It is loaded with N-1 on state entry, and the state exits when the count reaches 0.
- **Bus hold.** `o_lcd_data` and `o_lcd_rs` keep their last values in IDLE.
- **Panel controls.** `o_lcd_on` and `o_lcd_blon` are registered copies of `i_lcd_word[31]` and `[29]`, updated every cycle independently of the FSM.

## Timing
- Let the LSU write that flips GO take effect at edge N.
  - Edge N+1: FIFO push.
  - Edge N+2: the FSM leaves IDLE and the data/RS pins update.
  - Edge N+2+`TAS_CYC`: EN rises.
  - Edge N+2+`TAS_CYC`+`EN_CYC`: EN falls.
- Each transfer occupies `TAS_CYC`+`EN_CYC`+`HOLD_CYC`+exec cycles. With defaults this is 2031 cycles, or 82031 for clear/home.
- Back-to-back queued entries: the next IDLE→SETUP transition happens on the edge after EXEC ends, giving exactly one IDLE cycle between transfers.
- `o_busy` rises at edge N+1 and falls the cycle after the last EXEC ends with the FIFO empty.
- Toggling GO twice in consecutive cycles queues two entries with the same captured word values.

## Configuration
- **`LCD_AUTO_INIT_EN` defined.**
  - After reset the FSM enters INIT_WAIT for `INIT_CYC` cycles.
  - It then issues four internal RS=0 transfers through the normal SETUP→EXEC path: 0x38, 0x0C, 0x01 (slow), 0x06.
  - Only after these does it return to IDLE and start serving the FIFO.
  - `o_busy`=1 throughout INIT_WAIT and the init sequence.
  - GO pushes are accepted and queued during init.
- **Not defined.** The FSM resets to IDLE and software is responsible for initialising the panel.

## Test plan
- **Single write.** Set word=0x4000_0241 (GO=1, RS=1, data 0x41), with reset values for other runs at defaults.
  - Expect RS=1 and data=0x41 at N+2, EN high for exactly 25 cycles starting N+5, and `o_busy` low 2031 cycles after N+2.
- **Clear command.** Write RS=0, data=0x01 with GO toggled.
  - Expect the EXEC phase to last 82000 cycles.
  - Repeat with data 0x38; expect an EXEC phase of 2000 cycles.
- **FIFO full and overflow.** Toggle GO 6 times in consecutive cycles with data 0x10..0x15.
  - Expect 0x10..0x14 emitted in order (one popped, four queued), 0x15 dropped, and `o_overflow`=1 until reset.
- **Reset mid-PULSE.** Assert `i_reset`=0 while EN=1.
  - Expect EN, data, busy and overflow to be 0 asynchronously and the FIFO empty.
  - After release, no transfer occurs without a new GO toggle.
- **Panel controls.** Write word bits [31]=1, [29]=1 without toggling GO.
  - Expect `o_lcd_on`=1 and `o_lcd_blon`=1 one cycle later, with no EN pulse.
- **Auto-init (`LCD_AUTO_INIT_EN`, `INIT_CYC`=100).**
  - Expect 0x38, 0x0C, 0x01, 0x06 on the bus with RS=0 after 100 cycles.
  - A GO toggle during init is emitted fifth.
